icache_refill_responder: RTL and testbench
==========================================

// Module: icache_refill_responder
// PURPOSE
//  Memory-side AXI4 read responder answering the icache's line-refill bursts. Accepts one AR
//  request at a time and streams arlen+1 64-bit beats from an internal synchronous block-RAM
//  image at up to one beat per cycle, honouring R-channel backpressure. Serves as the refill
//  target in FPGA bring-up and simulation. A side port preloads the program image.
// PARAMETERS
//  MEM_BEATS   4096            depth of backing store in AXI_WIDTH-bit beats (power of two)
//  ID_W        4               AXI ID width
//  AXI_WIDTH   icache_pkg      data width, 64; beat = 8 bytes
// PORTS
//  clock        in   1              rising-edge clock
//  reset        in   1              synchronous, active-high
//  ar_valid     in   1              AR request valid
//  ar_ready     out  1              AR accept
//  ar_addr      in   WDSZ           byte address of first beat
//  ar_len       in   8              beats minus one (refill uses ALLOC_BEATS-1)
//  ar_size      in   3              must be 3 (8 bytes)
//  ar_burst     in   2              must be INCR (2'b01)
//  ar_id        in   ID_W           transaction ID
//  r_valid      out  1              R beat valid
//  r_ready      in   1              R beat accept
//  r_data       out  AXI_WIDTH      beat data
//  r_resp       out  2              OKAY / SLVERR / DECERR
//  r_last       out  1              final beat of burst
//  r_id         out  ID_W           echoed ar_id
//  init_we      in   1              preload write enable
//  init_addr    in   $clog2(MEM_BEATS) preload beat index
//  init_data    in   AXI_WIDTH      preload data
// BEHAVIOUR
//  Reset: ar_ready=0, r_valid=0, r_last=0, r_resp=OKAY, r_data=0, r_id=0; FSM->IDLE; skid emptied.
//  Memory contents are NOT cleared by reset.
//  FSM IDLE: ar_ready=1 (from first cycle after reset deasserts). On ar_valid&&ar_ready latch
//   id, len, beat index = ar_addr[..3] (low 3 bits ignored), err class; -> BURST. ar_ready=0.
//  FSM BURST: issue one BRAM read per cycle while skid has room and issued<len+1; beat index
//   increments by 1 per issue. When the beat with r_last is handshaken -> IDLE; ar_ready=1 the
//   cycle after (no AR/R overlap; one outstanding burst).
//  Latency: first r_valid exactly 2 cycles after AR handshake with r_ready held high; then
//   one beat/cycle, no bubbles, while r_ready=1.
//  Backpressure: r_valid/r_data/r_resp/r_last/r_id stable while r_valid&&!r_ready. 2-entry
//   skid absorbs the in-flight BRAM read; issue stalls when skid holds >=1 entry un-drained
//   such that no beat is ever dropped or duplicated.
//  Errors: ar_size!=3 or ar_burst!=INCR -> all len+1 beats r_resp=SLVERR, r_data=0.
//   Beat index >= MEM_BEATS (no wrap) -> that beat DECERR, r_data=0; in-range beats OKAY.
//   r_last always on beat len regardless of errors.
//  Preload vs read same index, same cycle: read returns OLD data (read-first). Preload
//   allowed any time; has no handshake and no effect on AXI outputs.
//  Reset mid-burst: burst abandoned, all outputs reach reset values next cycle; no r_last.
//  Counters: issue/return counters 9 bits (len+1 up to 256), no overflow possible.
// STRUCTURE
//  icache_pkg additions: axi_resp_t enum {OKAY=0,EXOKAY=1,SLVERR=2,DECERR=3},
//   axi_burst_t enum {FIXED,INCR,WRAP}, parameter AXI_BEAT_BYTES = AXI_WIDTH/8.
//  Sub-module: icache_r_skid -- 2-entry FIFO of {data,resp,last,id}, valid/ready both sides,
//   exposes count for the issue stall. BRAM array inferred inline (read-first, 1-cycle).
// TESTING
//  1 Preload beat i = {32'hA5A5_0000+i, i}; AR addr=0x0, len=31, r_ready=1 -> 32 OKAY beats,
//    data match, first r_valid 2 cycles after AR, r_last only on beat 31, r_id echoed.
//  2 Same burst, r_ready toggled random ~50% -> 32 beats in order, none lost/duplicated,
//    outputs stable while stalled.
//  3 AR ar_burst=WRAP (or ar_size=2), len=3 -> 4 beats SLVERR, data 0, r_last on 4th.
//  4 AR at beat MEM_BEATS-2, len=3 -> OKAY,OKAY,DECERR,DECERR; ar_ready low until r_last
//    taken, high next cycle; second AR accepted immediately then.
//  5 Assert reset at beat 10 of a 32-beat burst -> next cycle r_valid=0, ar_ready=0; then
//    ar_ready=1, new burst from beat 0 returns correct data.
//  6 init_we to index 5 in same cycle as BRAM read of index 5 -> old value returned; rerun
//    burst -> new value.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the icache refill path.
//   AXI_WIDTH       data width of one beat (64 bits)
//   AXI_BEAT_BYTES  bytes per beat
//   WDSZ            byte address width of the AR channel
//   axi_resp_t      AXI read response codes
//   axi_burst_t     AXI burst types
//   refill_state_t  responder FSM states
package icache_pkg;

  localparam int AXI_WIDTH      = 64;
  localparam int AXI_BEAT_BYTES = AXI_WIDTH / 8;
  localparam int WDSZ           = 32;

  // arsize encoding of one full-width beat (log2 of bytes per beat)
  localparam logic [2:0] AXI_SIZE_BEAT = 3'($clog2(AXI_BEAT_BYTES));

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi_burst_t;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } refill_state_t;

  // A malformed request poisons every beat; otherwise only beats past the
  // end of the backing store are reported as decode errors.
  function automatic axi_resp_t beat_resp(input logic bad_request,
                                          input logic out_of_range);
    if (bad_request)  return SLVERR;
    if (out_of_range) return DECERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/icache_r_skid.sv
// Two-entry FIFO sitting between the block-RAM read stage and the AXI R
// channel. Absorbs the read already in flight when the master stalls.
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_in_*  / o_in_ready      write side (beat from the BRAM stage)
//   o_out_* / i_out_ready     read side (AXI R channel)
//   o_count                   entries currently held (0..2)
// While empty the read-side payload is driven to zero so the R channel
// shows idle values rather than stale data.
module icache_r_skid
  import icache_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  axi_resp_t         i_in_resp,
  input  logic              i_in_last,
  input  logic [ID_W-1:0]   i_in_id,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output axi_resp_t         o_out_resp,
  output logic              o_out_last,
  output logic [ID_W-1:0]   o_out_id,
  output logic [1:0]        o_count
);

  localparam int ENTRY_W = DATA_W + 2 + 1 + ID_W;

  logic [ENTRY_W-1:0] r_entry [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [1:0]         w_head_resp;

  assign o_in_ready  = (r_count != 2'd2);
  assign o_out_valid = (r_count != 2'd0);
  assign o_count     = r_count;
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the occupancy count
  // alone decides whether an entry is meaningful.
  always_ff @(posedge i_clock) begin
    if (w_push) r_entry[r_wr_ptr] <= {i_in_data, i_in_resp, i_in_last, i_in_id};
  end

  assign w_head = o_out_valid ? r_entry[r_rd_ptr] : '0;
  assign {o_out_data, w_head_resp, o_out_last, o_out_id} = w_head;
  assign o_out_resp = axi_resp_t'(w_head_resp);

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side AXI4 read responder for icache line refills.
//   i_clock, i_reset       clock, synchronous active-high reset
//   i_ar_* / o_ar_ready    AR channel, one burst accepted at a time
//   o_r_* / i_r_ready      R channel, up to one beat per cycle
//   i_init_*               preload port into the backing block RAM
// Beats come from an inferred 1-cycle block RAM and pass through a 2-entry
// skid so R-channel backpressure never loses or repeats a beat.
module icache_refill_responder
  import icache_pkg::*;
#(
  parameter  int MEM_BEATS = 4096,
  parameter  int ID_W      = 4,
  localparam int MEM_AW    = $clog2(MEM_BEATS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_ar_valid,
  output logic                 o_ar_ready,
  input  logic [WDSZ-1:0]      i_ar_addr,
  input  logic [7:0]           i_ar_len,
  input  logic [2:0]           i_ar_size,
  input  logic [1:0]           i_ar_burst,
  input  logic [ID_W-1:0]      i_ar_id,
  output logic                 o_r_valid,
  input  logic                 i_r_ready,
  output logic [AXI_WIDTH-1:0] o_r_data,
  output axi_resp_t            o_r_resp,
  output logic                 o_r_last,
  output logic [ID_W-1:0]      o_r_id,
  input  logic                 i_init_we,
  input  logic [MEM_AW-1:0]    i_init_addr,
  input  logic [AXI_WIDTH-1:0] i_init_data
);

  localparam int BEAT_SHIFT = $clog2(AXI_BEAT_BYTES);
  // One spare bit so a burst running past the top of the address space
  // keeps counting upward instead of wrapping back into the store.
  localparam int IDX_W = WDSZ - BEAT_SHIFT + 1;

  logic [AXI_WIDTH-1:0] r_mem [MEM_BEATS];
  logic [AXI_WIDTH-1:0] r_mem_q;

  refill_state_t   r_state;
  refill_state_t   w_state_next;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_len;
  logic [IDX_W-1:0] r_beat_idx;
  logic            r_slverr;
  logic [8:0]      r_issued;
  logic            r_rd_valid;
  axi_resp_t       r_rd_resp;
  logic            r_rd_last;

  logic            w_ar_ready;
  logic            w_ar_hs;
  logic            w_issue;
  logic            w_room;
  logic            w_r_pop;
  logic            w_skid_in_ready;
  logic [1:0]      w_skid_count;
  axi_resp_t       w_issue_resp;
  logic            w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^i_ar_addr[BEAT_SHIFT-1:0];

  assign o_ar_ready = w_ar_ready && !i_reset;
  assign w_ar_hs    = i_ar_valid && o_ar_ready;
  assign w_r_pop    = o_r_valid && i_r_ready;

  // Issue only if the skid can hold this read plus the one already in
  // flight, counting the entry that leaves this cycle.
  assign w_room = w_skid_in_ready &&
                  (({1'b0, w_skid_count} + {2'b0, r_rd_valid}) < (3'd2 + {2'b0, w_r_pop}));
  assign w_issue = (r_state == ST_BURST) && (r_issued <= {1'b0, r_len}) && w_room;
  assign w_issue_resp = beat_resp(r_slverr, r_beat_idx >= IDX_W'(MEM_BEATS));

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    w_state_next = r_state;
    w_ar_ready   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ar_ready = 1'b1;
        if (i_ar_valid) w_state_next = ST_BURST;
      end
      ST_BURST: begin
        if (w_r_pop && o_r_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_id       <= '0;
      r_len      <= '0;
      r_beat_idx <= '0;
      r_slverr   <= 1'b0;
      r_issued   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_resp  <= OKAY;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_issue;
      if (w_ar_hs) begin
        r_id       <= i_ar_id;
        r_len      <= i_ar_len;
        r_beat_idx <= {1'b0, i_ar_addr[WDSZ-1:BEAT_SHIFT]};
        r_slverr   <= (i_ar_size != AXI_SIZE_BEAT) || (i_ar_burst != INCR);
        r_issued   <= '0;
      end else if (w_issue) begin
        r_beat_idx <= r_beat_idx + 1'b1;
        r_issued   <= r_issued + 9'd1;
        r_rd_resp  <= w_issue_resp;
        r_rd_last  <= (r_issued == {1'b0, r_len});
      end
    end
  end

  // NOTE: write and read share one clocked block, so a read of the index
  // being preloaded on the same edge returns the old contents (read-first).
  always_ff @(posedge i_clock) begin
    if (i_init_we) r_mem[i_init_addr] <= i_init_data;
    if (w_issue)   r_mem_q <= r_mem[r_beat_idx[MEM_AW-1:0]];
  end

  icache_r_skid #(
    .DATA_W (AXI_WIDTH),
    .ID_W   (ID_W)
  ) u_skid (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_in_valid  (r_rd_valid),
    .o_in_ready  (w_skid_in_ready),
    .i_in_data   ((r_rd_resp == OKAY) ? r_mem_q : '0),
    .i_in_resp   (r_rd_resp),
    .i_in_last   (r_rd_last),
    .i_in_id     (r_id),
    .o_out_valid (o_r_valid),
    .i_out_ready (i_r_ready),
    .o_out_data  (o_r_data),
    .o_out_resp  (o_r_resp),
    .o_out_last  (o_r_last),
    .o_out_id    (o_r_id),
    .o_count     (w_skid_count)
  );

endmodule

// File: tb/tb_icache_refill_responder.sv
// Self-checking bench for icache_refill_responder. A burst-level model turns
// each accepted AR into the list of beats the responder owes; a single
// negedge process compares the R channel and ar_ready against it.
module tb_icache_refill_responder;
  import icache_pkg::*;

  localparam int MEM_BEATS = 4096;
  localparam int ID_W      = 4;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_ar_valid = 1'b0;
  logic            o_ar_ready;
  logic [31:0]     i_ar_addr = '0;
  logic [7:0]      i_ar_len = '0;
  logic [2:0]      i_ar_size = 3'd3;
  logic [1:0]      i_ar_burst = 2'b01;
  logic [ID_W-1:0] i_ar_id = '0;
  logic            o_r_valid;
  logic            i_r_ready = 1'b1;
  logic [63:0]     o_r_data;
  axi_resp_t       o_r_resp;
  logic            o_r_last;
  logic [ID_W-1:0] o_r_id;
  logic            i_init_we = 1'b0;
  logic [11:0]     i_init_addr = '0;
  logic [63:0]     i_init_data = '0;

  always #5 clk = ~clk;

  icache_refill_responder #(.MEM_BEATS(MEM_BEATS), .ID_W(ID_W)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_ar_valid(i_ar_valid), .o_ar_ready(o_ar_ready), .i_ar_addr(i_ar_addr),
    .i_ar_len(i_ar_len), .i_ar_size(i_ar_size), .i_ar_burst(i_ar_burst), .i_ar_id(i_ar_id),
    .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_data(o_r_data), .o_r_resp(o_r_resp),
    .o_r_last(o_r_last), .o_r_id(o_r_id),
    .i_init_we(i_init_we), .i_init_addr(i_init_addr), .i_init_data(i_init_data)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
    int          cyc;
  } beat_t;

  beat_t       exp_q[$];   // beats still owed for the current burst
  beat_t       log_b[$];   // every beat accepted on R, in order
  logic [63:0] mm [int];   // model of the backing store
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          rst_q = 1'b0;
  bit          busy = 1'b0;
  bit          first_pending = 1'b0;
  int          ar_cyc = 0;
  bit          prev_stall = 1'b0;
  logic [71:0] prev_bus = '0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pattern(input int i);
    logic [31:0] hi;
    hi = 32'hA5A5_0000 + 32'(i);
    return {hi, 32'(i)};
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= i_reset;
  end

  // The expected beat list is fixed when the AR is accepted; the bench never
  // preloads an index that a running burst has yet to read, so the store as
  // seen at AR time is the store each read sees.
  always @(negedge clk) begin
    logic [71:0] bus;
    beat_t b;
    longint idx;
    bus = {o_r_valid, o_r_data, o_r_resp, o_r_last, o_r_id};
    check("ar_ready", o_ar_ready, !busy && !i_reset);
    if (rst_q) begin
      check("reset r_valid", o_r_valid, 0);
      check("reset r_data", o_r_data, 0);
      check("reset r_resp", o_r_resp, 0);
      check("reset r_last", o_r_last, 0);
      check("reset r_id", o_r_id, 0);
    end
    if (i_reset) begin
      exp_q.delete();
      busy = 1'b0;
      first_pending = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall hold", bus, prev_bus);
      if (exp_q.size() == 0) begin
        check("spurious r_valid", o_r_valid, 0);
      end else if (o_r_valid) begin
        if (first_pending) begin
          check("first beat latency", 72'(cyc - ar_cyc), 2);
          first_pending = 1'b0;
        end
        check("r_data", o_r_data, exp_q[0].data);
        check("r_resp", o_r_resp, exp_q[0].resp);
        check("r_last", o_r_last, exp_q[0].last);
        check("r_id", o_r_id, exp_q[0].id);
        if (i_r_ready) begin
          log_b.push_back('{o_r_data, o_r_resp, o_r_last, o_r_id, cyc});
          if (exp_q[0].last) busy = 1'b0;
          void'(exp_q.pop_front());
        end
      end
      prev_stall = o_r_valid && !i_r_ready;
      prev_bus   = bus;
      if (i_ar_valid && o_ar_ready) begin
        for (int k = 0; k <= int'(i_ar_len); k++) begin
          idx    = longint'(i_ar_addr >> 3) + k;
          b.id   = i_ar_id;
          b.last = (k == int'(i_ar_len));
          b.cyc  = 0;
          if (i_ar_size != 3'd3 || i_ar_burst != 2'b01) begin
            b.resp = 2'd2; b.data = '0;
          end else if (idx >= MEM_BEATS) begin
            b.resp = 2'd3; b.data = '0;
          end else begin
            b.resp = 2'd0; b.data = mm[int'(idx)];
          end
          exp_q.push_back(b);
        end
        busy = 1'b1;
        ar_cyc = cyc + 1;
        first_pending = 1'b1;
      end
      if (i_init_we) mm[int'(i_init_addr)] = i_init_data;
    end
  end

  task automatic preload(input int idx, input logic [63:0] data);
    @(posedge clk); #1;
    i_init_we = 1'b1; i_init_addr = 12'(idx); i_init_data = data;
    @(posedge clk); #1;
    i_init_we = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, output int hs_cyc);
    int n;
    @(posedge clk); #1;
    i_ar_valid = 1'b1; i_ar_addr = addr; i_ar_len = len;
    i_ar_size = size; i_ar_burst = burst; i_ar_id = id;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_ar_ready && n < 300);
    check("ar accepted within budget", o_ar_ready, 1);
    hs_cyc = cyc;
    @(posedge clk); #1;
    i_ar_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      if (rnd) i_r_ready = 1'($urandom_range(0, 1));
      n++;
    end
    i_r_ready = 1'b1;
    check("burst completes within budget", busy, 0);
    check("no beats left owed", exp_q.size(), 0);
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit rnd);
    int hs;
    send_ar(addr, len, size, burst, id, hs);
    wait_idle(rnd);
  endtask

  initial begin
    int base, hs1, hs2, n;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    for (int i = 0; i < 32; i++) preload(i, pattern(i));
    preload(4094, pattern(4094));
    preload(4095, pattern(4095));

    // 1: straight 32-beat refill with r_ready held high
    base = log_b.size();
    run_burst(32'h0, 8'd31, 3'd3, INCR, 4'h3, 1'b0);
    check("t1 beat count", log_b.size() - base, 32);
    check("t1 beat0 data", log_b[base].data, 64'hA5A5_0000_0000_0000);
    check("t1 beat31 data", log_b[base+31].data, 64'hA5A5_001F_0000_001F);
    check("t1 beat30 not last", log_b[base+30].last, 0);
    check("t1 beat31 last", log_b[base+31].last, 1);
    check("t1 id echoed", log_b[base+31].id, 4'h3);
    check("t1 no bubbles", 72'(log_b[base+31].cyc - log_b[base].cyc), 31);

    // 2: same burst under random backpressure
    base = log_b.size();
    run_burst(32'h0, 8'd31, 3'd3, INCR, 4'hA, 1'b1);
    check("t2 beat count", log_b.size() - base, 32);
    check("t2 beat17 data", log_b[base+17].data, 64'hA5A5_0011_0000_0011);

    // 3: malformed requests
    base = log_b.size();
    run_burst(32'h0, 8'd3, 3'd3, WRAP, 4'h2, 1'b0);
    check("t3 wrap resp", log_b[base].resp, 2'd2);
    check("t3 wrap data", log_b[base+1].data, 0);
    check("t3 wrap last on 4th", log_b[base+3].last, 1);
    base = log_b.size();
    run_burst(32'h8, 8'd3, 3'd2, INCR, 4'h4, 1'b0);
    check("t3 size2 resp", log_b[base+2].resp, 2'd2);

    // 4: burst crossing the end of the store, next AR queued behind it
    base = log_b.size();
    send_ar(32'((MEM_BEATS - 2) * 8), 8'd3, 3'd3, INCR, 4'h5, hs1);
    send_ar(32'h10, 8'd1, 3'd3, INCR, 4'h6, hs2);
    wait_idle(1'b0);
    check("t4 beat0 okay", log_b[base].resp, 2'd0);
    check("t4 beat1 data", log_b[base+1].data, 64'hA5A5_0FFF_0000_0FFF);
    check("t4 beat2 decerr", log_b[base+2].resp, 2'd3);
    check("t4 beat3 decerr", log_b[base+3].resp, 2'd3);
    check("t4 beat3 data", log_b[base+3].data, 0);
    check("t4 next AR right after r_last", 72'(hs2 - log_b[base+3].cyc), 1);
    check("t4 second burst data", log_b[base+4].data, 64'hA5A5_0002_0000_0002);

    // 5: reset in the middle of a burst
    base = log_b.size();
    send_ar(32'h0, 8'd31, 3'd3, INCR, 4'h7, hs1);
    n = 0;
    while (log_b.size() - base < 10 && n < 500) begin @(negedge clk); n++; end
    check("t5 reached beat 10", (log_b.size() - base) >= 10, 1);
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t5 r_valid after reset", o_r_valid, 0);
    check("t5 ar_ready during reset", o_ar_ready, 0);
    check("t5 abandoned burst had no r_last", log_b[log_b.size()-1].last, 0);
    @(posedge clk); #1 i_reset = 1'b0;
    base = log_b.size();
    run_burst(32'h0, 8'd31, 3'd3, INCR, 4'h9, 1'b0);
    check("t5 restart beat0", log_b[base].data, 64'hA5A5_0000_0000_0000);
    check("t5 restart beat10", log_b[base+10].data, 64'hA5A5_000A_0000_000A);

    // 6: preload of index 5 on the very edge that reads it
    base = log_b.size();
    send_ar(32'h0, 8'd31, 3'd3, INCR, 4'h1, hs1);
    repeat (5) @(posedge clk);
    #1 i_init_we = 1'b1; i_init_addr = 12'd5; i_init_data = 64'hDEAD_BEEF_0000_0005;
    @(posedge clk); #1 i_init_we = 1'b0;
    wait_idle(1'b0);
    check("t6 same-edge read sees old", log_b[base+5].data, 64'hA5A5_0005_0000_0005);
    base = log_b.size();
    run_burst(32'h0, 8'd31, 3'd3, INCR, 4'h1, 1'b0);
    check("t6 rerun sees new", log_b[base+5].data, 64'hDEAD_BEEF_0000_0005);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
